// File: rtl/gate_chain_sequencer.sv
// gate_chain_sequencer: folds a stream of 2x2 gate matrices into a running
// product P = G_n * ... * G_1 using an external matrix_multiplier, then hands
// the final product downstream over a valid/ready handshake.
module gate_chain_sequencer #(
    parameter logic [18:0] ONE   = 19'h10000,
    parameter int          CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    // incoming gate stream
    input  logic [18:0]      gate_r1c1,
    input  logic [18:0]      gate_r1c2,
    input  logic [18:0]      gate_r2c1,
    input  logic [18:0]      gate_r2c2,
    input  logic             gate_valid,
    input  logic             gate_last,
    output logic             gate_ready,
    // multiplier A operand (newest gate)
    output logic [18:0]      mtx_a_r1c1,
    output logic [18:0]      mtx_a_r1c2,
    output logic [18:0]      mtx_a_r2c1,
    output logic [18:0]      mtx_a_r2c2,
    output logic             mtx_a_ready,
    // multiplier B operand (running product)
    output logic [18:0]      mtx_b_r1c1,
    output logic [18:0]      mtx_b_r1c2,
    output logic [18:0]      mtx_b_r2c1,
    output logic [18:0]      mtx_b_r2c2,
    output logic             mtx_b_ready,
    // multiplier result
    input  logic [18:0]      mtx_r_r1c1,
    input  logic [18:0]      mtx_r_r1c2,
    input  logic [18:0]      mtx_r_r2c1,
    input  logic [18:0]      mtx_r_r2c2,
    input  logic             completed,
    // final product
    output logic [18:0]      prod_r1c1,
    output logic [18:0]      prod_r1c2,
    output logic [18:0]      prod_r2c1,
    output logic [18:0]      prod_r2c2,
    output logic             prod_valid,
    input  logic             prod_ready,
    output logic [CNT_W-1:0] gate_count
);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        MUL    = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // matrix words packed as [r1c1, r1c2, r2c1, r2c2] in index order 0..3
    typedef logic [3:0][18:0] mat_t;

    localparam mat_t            IDENT   = '{3: ONE, 2: 19'd0, 1: 19'd0, 0: ONE};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    mat_t             a_q, a_d;
    mat_t             acc_q, acc_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    mat_t gate_w, res_w;
    assign gate_w = '{3: gate_r2c2, 2: gate_r2c1, 1: gate_r1c2, 0: gate_r1c1};
    assign res_w  = '{3: mtx_r_r2c2, 2: mtx_r_r2c1, 1: mtx_r_r1c2, 0: mtx_r_r1c1};

    // next-state logic: every register holds unless the current state updates it
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ACCEPT: begin
                if (gate_valid) begin
                    a_d     = gate_w;
                    last_d  = gate_last;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    state_d = MUL;
                end
            end
            MUL: begin
                // a completion already high on entry is a genuine one: the
                // stale tail of the previous one was absorbed in DRAIN
                if (completed) begin
                    acc_d   = res_w;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // multiplier keeps completed high for two edges after ready drops
                if (!completed) begin
                    state_d = last_q ? DONE : ACCEPT;
                end
            end
            DONE: begin
                if (prod_ready) begin
                    acc_d   = IDENT;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    // state and datapath registers, asynchronously returned to identity/idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCEPT;
            a_q     <= '0;
            acc_q   <= IDENT;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // handshake outputs decode state only, so reset reaches them immediately
    assign gate_ready  = (state_q == ACCEPT);
    assign mtx_a_ready = (state_q == MUL);
    assign mtx_b_ready = (state_q == MUL);
    assign prod_valid  = (state_q == DONE);
    assign gate_count  = cnt_q;

    assign mtx_a_r1c1 = a_q[0];
    assign mtx_a_r1c2 = a_q[1];
    assign mtx_a_r2c1 = a_q[2];
    assign mtx_a_r2c2 = a_q[3];

    assign mtx_b_r1c1 = acc_q[0];
    assign mtx_b_r1c2 = acc_q[1];
    assign mtx_b_r2c1 = acc_q[2];
    assign mtx_b_r2c2 = acc_q[3];

    assign prod_r1c1  = acc_q[0];
    assign prod_r1c2  = acc_q[1];
    assign prod_r2c1  = acc_q[2];
    assign prod_r2c2  = acc_q[3];

endmodule

// File: tb/tb_gate_chain_sequencer.sv
// Bench for gate_chain_sequencer: behavioural matrix_multiplier model plus a
// scoreboard of expected chain products, compared when the DUT presents them.
module tb_gate_chain_sequencer;

    typedef logic [3:0][18:0] mat_t;
    localparam int   CW = 3;
    localparam mat_t ID = '{3: 19'h10000, 2: 19'd0, 1: 19'd0, 0: 19'h10000};
    localparam mat_t MX = '{3: 19'd0, 2: 19'h10000, 1: 19'h10000, 0: 19'd0};
    localparam mat_t MZ = '{3: 19'h70000, 2: 19'd0, 1: 19'd0, 0: 19'h10000};

    logic clk, rst;
    mat_t gate_m, a_m, b_m, r_m, p_m;
    logic gate_valid, gate_last, gate_ready;
    logic a_rdy, b_rdy, completed, prod_valid, prod_ready;
    logic [CW-1:0] gate_count;

    int checks = 0, failures = 0;
    int cyc = 0, acc_cyc = 0;
    mat_t exp_acc;
    mat_t sb[$];

    gate_chain_sequencer #(.ONE(19'h10000), .CNT_W(CW)) dut (
        .clk(clk), .reset(rst),
        .gate_r1c1(gate_m[0]), .gate_r1c2(gate_m[1]), .gate_r2c1(gate_m[2]), .gate_r2c2(gate_m[3]),
        .gate_valid(gate_valid), .gate_last(gate_last), .gate_ready(gate_ready),
        .mtx_a_r1c1(a_m[0]), .mtx_a_r1c2(a_m[1]), .mtx_a_r2c1(a_m[2]), .mtx_a_r2c2(a_m[3]),
        .mtx_a_ready(a_rdy),
        .mtx_b_r1c1(b_m[0]), .mtx_b_r1c2(b_m[1]), .mtx_b_r2c1(b_m[2]), .mtx_b_r2c2(b_m[3]),
        .mtx_b_ready(b_rdy),
        .mtx_r_r1c1(r_m[0]), .mtx_r_r1c2(r_m[1]), .mtx_r_r2c1(r_m[2]), .mtx_r_r2c2(r_m[3]),
        .completed(completed),
        .prod_r1c1(p_m[0]), .prod_r1c2(p_m[1]), .prod_r2c1(p_m[2]), .prod_r2c2(p_m[3]),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .gate_count(gate_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // signed Q2.16 product, wrapping to 19 bits
    function automatic logic [18:0] fx(input logic [18:0] a, input logic [18:0] b);
        logic signed [37:0] p;
        p = $signed(a) * $signed(b);
        return p[34:16];
    endfunction

    function automatic mat_t mmul(input mat_t a, input mat_t b);
        mat_t r;
        logic [18:0] s;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = '0;
                for (int k = 0; k < 2; k++) s = s + fx(a[2*i+k], b[2*k+j]);
                r[2*i+j] = s;
            end
        return r;
    endfunction

    // multiplier model: completed after two sampled ready edges, held for
    // two edges after ready drops
    int mcnt, mhold;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            completed <= 1'b0;
            r_m       <= '0;
            mcnt      <= 0;
            mhold     <= 0;
        end else if (!completed) begin
            if (a_rdy && b_rdy) begin
                if (mcnt == 1) begin
                    completed <= 1'b1;
                    r_m       <= mmul(a_m, b_m);
                    mcnt      <= 0;
                    mhold     <= 0;
                end else mcnt <= mcnt + 1;
            end else mcnt <= 0;
        end else if (!a_rdy) begin
            if (mhold == 1) completed <= 1'b0;
            mhold <= mhold + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send_gate(input mat_t g, input logic last);
        int n;
        gate_m = g; gate_last = last; gate_valid = 1'b1;
        n = 0;
        while (!gate_ready && n < 50) begin @(negedge clk); n++; end
        if (!gate_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            gate_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            acc_cyc = cyc;
            gate_valid = 1'b0; gate_last = 1'b0;
            exp_acc = mmul(g, exp_acc);
            if (last) begin
                sb.push_back(exp_acc);
                exp_acc = ID;
            end
        end
    endtask

    // waits for prod_valid, compares against the scoreboard, then accepts
    task automatic recv_prod(input string tag, output int lat);
        int n;
        mat_t e;
        n = 0; lat = -1;
        while (!prod_valid && n < 50) begin @(negedge clk); n++; end
        if (!prod_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else begin
            lat = cyc - acc_cyc;
            if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            else begin
                e = sb.pop_front();
                for (int i = 0; i < 4; i++)
                    chk($sformatf("%s_p%0d", tag, i), 32'(p_m[i]), 32'(e[i]));
            end
            prod_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            prod_ready = 1'b0;
            chk({tag, "_valid_drop"}, 32'(prod_valid), 32'd0);
            chk({tag, "_ready_back"}, 32'(gate_ready), 32'd1);
        end
    endtask

    initial begin
        int lat, t0, n;
        gate_m = '0; gate_valid = 1'b0; gate_last = 1'b0; prod_ready = 1'b0;
        exp_acc = ID;
        rst = 1'b1;
        #1;
        chk("rst_gate_ready", 32'(gate_ready), 32'd1);
        chk("rst_prod_valid", 32'(prod_valid), 32'd0);
        chk("rst_a_ready", 32'(a_rdy), 32'd0);
        chk("rst_count", 32'(gate_count), 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_acc%0d", i), 32'(p_m[i]), 32'(ID[i]));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single gate
        send_gate(MZ, 1'b1);
        chk("single_count", 32'(gate_count), 32'd1);
        recv_prod("single", lat);
        chk("single_latency", 32'(lat), 32'd6);

        // order: X then Z gives Z*X, back-to-back accept interval is 7
        send_gate(MX, 1'b0);
        t0 = acc_cyc;
        send_gate(MZ, 1'b1);
        chk("order_interval", 32'(acc_cyc - t0), 32'd7);
        n = 0;
        while (!prod_valid && n < 50) begin @(negedge clk); n++; end
        chk("order_count", 32'(gate_count), 32'd2);
        chk("order_literal_r2c1", 32'(p_m[2]), 32'h70000);
        recv_prod("order", lat);

        // self-inverse
        send_gate(MX, 1'b0);
        send_gate(MX, 1'b1);
        recv_prod("selfinv", lat);

        // backpressure with gate_valid held high
        send_gate(MZ, 1'b1);
        n = 0;
        while (!prod_valid && n < 50) begin @(negedge clk); n++; end
        gate_m = MX; gate_valid = 1'b1; gate_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(prod_valid), 32'd1);
            chk("bp_gate_ready", 32'(gate_ready), 32'd0);
            chk("bp_a_ready", 32'(a_rdy), 32'd0);
            for (int i = 0; i < 4; i++) chk($sformatf("bp_p%0d", i), 32'(p_m[i]), 32'(MZ[i]));
        end
        gate_valid = 1'b0; gate_last = 1'b0;
        recv_prod("bp", lat);
        send_gate(MZ, 1'b1);
        recv_prod("bp_after", lat);

        // reset during MUL discards the chain
        send_gate(MX, 1'b0);
        chk("mul_a_ready", 32'(a_rdy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mulrst_a_ready", 32'(a_rdy), 32'd0);
        chk("mulrst_b_ready", 32'(b_rdy), 32'd0);
        chk("mulrst_count", 32'(gate_count), 32'd0);
        chk("mulrst_gate_ready", 32'(gate_ready), 32'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("mulrst_acc%0d", i), 32'(p_m[i]), 32'(ID[i]));
        @(negedge clk);
        rst = 1'b0;
        exp_acc = ID;
        @(negedge clk);
        send_gate(MZ, 1'b1);
        recv_prod("mulrst_after", lat);

        // count saturation: nine X gates, count pinned at 7, product X
        for (int g = 0; g < 9; g++) send_gate(MX, g == 8);
        n = 0;
        while (!prod_valid && n < 50) begin @(negedge clk); n++; end
        chk("sat_count", 32'(gate_count), 32'd7);
        recv_prod("sat", lat);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
